// File: rtl/eth_tx_frame_arbiter_if.sv
`default_nettype none
// ============================================================================
// eth_tx_frame_arbiter_if
// AXI-Stream bundle between NumIn requesters, the frame arbiter and the TX framer.
// Revision: 1.0
// ============================================================================
interface eth_tx_frame_arbiter_if #(
    parameter int NumIn     = 4,
    parameter int DataWidth = 8,
    parameter int UserWidth = 1
);
    logic [NumIn*DataWidth-1:0] in_tdata;
    logic [NumIn*UserWidth-1:0] in_tuser;
    logic [NumIn-1:0]           in_tlast;
    logic [NumIn-1:0]           in_tvalid;
    logic [NumIn-1:0]           in_tready;
    logic [DataWidth-1:0]       out_tdata;
    logic [UserWidth-1:0]       out_tuser;
    logic                       out_tlast;
    logic                       out_tvalid;
    logic                       out_tready;

    // Environment side: drives the requester streams, sinks the output stream.
    modport master (
        output in_tdata, in_tuser, in_tlast, in_tvalid, out_tready,
        input  in_tready, out_tdata, out_tuser, out_tlast, out_tvalid
    );

    // Arbiter side.
    modport slave (
        input  in_tdata, in_tuser, in_tlast, in_tvalid, out_tready,
        output in_tready, out_tdata, out_tuser, out_tlast, out_tvalid
    );
endinterface
`default_nettype wire

// File: rtl/eth_tx_frame_arbiter.sv
`default_nettype none
// ============================================================================
// eth_tx_frame_arbiter
// Frame-atomic round-robin arbiter onto one AXI-Stream, with max-length truncation.
// Revision: 1.0
// ============================================================================
module eth_tx_frame_arbiter #(
    parameter int NumIn     = 4,
    parameter int DataWidth = 8,
    parameter int UserWidth = 1,
    parameter int MaxBeats  = 1518
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    eth_tx_frame_arbiter_if.slave bus,
    output logic [((NumIn > 1) ? $clog2(NumIn) : 1)-1:0] grant_o,
    output logic                  busy_o,
    output logic                  trunc_o
);
    localparam int GrantW = (NumIn > 1) ? $clog2(NumIn) : 1;
    localparam int CntW   = $clog2(MaxBeats + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [GrantW-1:0]   grant_q, grant_d;
    logic [GrantW-1:0]   rr_q, rr_d;
    logic [CntW-1:0]     beat_q, beat_d;
    logic                trunc_q, trunc_d;

    logic [GrantW-1:0]   pick;
    logic [GrantW-1:0]   rr_next;
    logic                found;
    int                  idx;
    logic                g_valid, g_last, at_limit;
    logic [DataWidth-1:0] g_data;
    logic [UserWidth-1:0] g_user;

    // First valid requester starting at rr_q, wrapping modulo NumIn.
    always_comb begin
        pick  = rr_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NumIn; k++) begin
            idx = (int'(rr_q) + k) % NumIn;
            if (!found && bus.in_tvalid[idx]) begin
                pick  = GrantW'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        g_valid  = bus.in_tvalid[grant_q];
        g_last   = bus.in_tlast[grant_q];
        g_data   = bus.in_tdata[grant_q*DataWidth +: DataWidth];
        g_user   = bus.in_tuser[grant_q*UserWidth +: UserWidth];
        at_limit = (beat_q == CntW'(MaxBeats - 1));
        rr_next  = GrantW'((int'(grant_q) + 1) % NumIn);
    end

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        rr_d           = rr_q;
        beat_d         = beat_q;
        trunc_d        = 1'b0;
        bus.in_tready  = '0;
        bus.out_tvalid = 1'b0;
        bus.out_tdata  = '0;
        bus.out_tuser  = '0;
        bus.out_tlast  = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_i && (|bus.in_tvalid)) begin
                    grant_d = pick;
                    beat_d  = '0;
                    state_d = FWD;
                end
            end
            FWD: begin
                bus.out_tvalid         = g_valid;
                bus.out_tdata          = g_data;
                bus.out_tuser          = g_user;
                // The last permitted beat is forced to close the frame as errored.
                bus.out_tuser[0]       = g_user[0] | (at_limit & ~g_last);
                bus.out_tlast          = g_last | at_limit;
                bus.in_tready[grant_q] = bus.out_tready;
                if (g_valid && bus.out_tready) begin
                    beat_d = beat_q + 1'b1;
                    if (g_last) begin
                        state_d = IDLE;
                        rr_d    = rr_next;
                    end else if (at_limit) begin
                        state_d = DROP;
                        trunc_d = 1'b1;
                    end
                end
            end
            DROP: begin
                bus.in_tready[grant_q] = 1'b1;
                if (g_valid && g_last) begin
                    state_d = IDLE;
                    rr_d    = rr_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            beat_q  <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
            trunc_q <= trunc_d;
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = (state_q != IDLE);
    assign trunc_o = trunc_q;
endmodule
`default_nettype wire

// File: tb/tb_eth_tx_frame_arbiter.sv
`default_nettype none
// ============================================================================
// tb_eth_tx_frame_arbiter
// Directed, table-driven bench for the frame arbiter (4 inputs, MaxBeats=16).
// Revision: 1.0
// ============================================================================
module tb_eth_tx_frame_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int UW = 1;
    localparam int MB = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] grant;
    logic       busy, trunc;

    always #5 clk = ~clk;

    eth_tx_frame_arbiter_if #(.NumIn(N), .DataWidth(DW), .UserWidth(UW)) bus ();

    eth_tx_frame_arbiter #(
        .NumIn(N), .DataWidth(DW), .UserWidth(UW), .MaxBeats(MB)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .en_i    (en),
        .bus     (bus),
        .grant_o (grant),
        .busy_o  (busy),
        .trunc_o (trunc)
    );

    // Source beat: {last, user, data}; captured output beat: {grant, last, user, data}.
    typedef logic [9:0] beat_t;
    beat_t       srcq [N][$];
    logic [11:0] outq [$];
    bit          mid [N];
    bit          rnd_rdy, rnd_bub;
    int          n_tests, n_fail, busy_cnt, trunc_cnt;

    typedef struct {
        int src;
        int len;
        int base;
        int beats;
        int err;
        int trunc;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input int src, input int len, input int base);
        for (int k = 0; k < len; k++) begin
            beat_t b;
            b = {(k == len - 1), 1'b0, 8'(base + k)};
            srcq[src].push_back(b);
        end
    endtask

    function automatic bit all_empty();
        bit e;
        e = 1'b1;
        for (int i = 0; i < N; i++) if (srcq[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    // Drive on the falling edge, observe 1 ns later, DUT commits on the next rising edge.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            bit bub;
            bub = rnd_bub && mid[i] && ($urandom_range(0, 2) == 0);
            if (srcq[i].size() > 0 && !bub) begin
                bus.in_tvalid[i]           = 1'b1;
                bus.in_tdata[i*DW +: DW]   = srcq[i][0][7:0];
                bus.in_tuser[i]            = srcq[i][0][8];
                bus.in_tlast[i]            = srcq[i][0][9];
            end else begin
                bus.in_tvalid[i]           = 1'b0;
                bus.in_tdata[i*DW +: DW]   = '0;
                bus.in_tuser[i]            = 1'b0;
                bus.in_tlast[i]            = 1'b0;
            end
        end
        bus.out_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (busy)  busy_cnt++;
        if (trunc) trunc_cnt++;
        if (bus.out_tvalid && bus.out_tready)
            outq.push_back({grant, bus.out_tlast, bus.out_tuser[0], bus.out_tdata});
        for (int i = 0; i < N; i++) begin
            beat_t b;
            if (bus.in_tvalid[i] && bus.in_tready[i]) begin
                b      = srcq[i].pop_front();
                mid[i] = !b[9];
            end
        end
    endtask

    task automatic run(input string name, input int budget);
        int  c;
        bit  done;
        c    = 0;
        done = 1'b0;
        while (!done && c < budget) begin
            tick();
            c++;
            if (all_empty() && !busy) done = 1'b1;
        end
        check({name, "_done"}, int'(done), 1);
    endtask

    task automatic expect_frame(input string name, input int src, input int nbeats,
                                input int base, input int err);
        for (int k = 0; k < nbeats; k++) begin
            logic [11:0] exp;
            int          act;
            exp = {2'(src), (k == nbeats - 1), (err != 0) && (k == nbeats - 1), 8'(base + k)};
            act = (outq.size() > 0) ? int'(outq.pop_front()) : -1;
            check(name, act, int'(exp));
        end
    endtask

    task automatic clear_env();
        for (int i = 0; i < N; i++) begin
            srcq[i].delete();
            mid[i] = 1'b0;
        end
        outq.delete();
        bus.in_tvalid  = '0;
        bus.in_tdata   = '0;
        bus.in_tuser   = '0;
        bus.in_tlast   = '0;
        bus.out_tready = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        clear_env();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [6];
        int   c;
        n_tests = 0;
        n_fail  = 0;
        rnd_rdy = 1'b0;
        rnd_bub = 1'b0;
        rst_n   = 1'b0;
        en      = 1'b1;
        clear_env();
        bus.in_tvalid = '1;

        // Reset state, with requests pending to show nothing is granted.
        repeat (3) @(negedge clk);
        #1;
        check("rst_grant",  int'(grant), 0);
        check("rst_busy",   int'(busy), 0);
        check("rst_trunc",  int'(trunc), 0);
        check("rst_ovalid", int'(bus.out_tvalid), 0);
        check("rst_ready",  int'(bus.in_tready), 0);
        check("rst_odata",  int'({bus.out_tlast, bus.out_tuser, bus.out_tdata}), 0);
        en = 1'b0;
        clear_env();
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;

        // src, len, base, beats out, error flag, trunc pulses
        tbl[0] = '{0,  8, 'h10,  8, 0, 0};
        tbl[1] = '{2, 20, 'h40, 16, 1, 1};
        tbl[2] = '{1, 16, 'h60, 16, 0, 0};
        tbl[3] = '{3,  1, 'hA0,  1, 0, 0};
        tbl[4] = '{3, 17, 'hB0, 16, 1, 1};
        tbl[5] = '{0, 15, 'hC0, 15, 0, 0};
        for (int v = 0; v < 6; v++) begin
            busy_cnt  = 0;
            trunc_cnt = 0;
            push_frame(tbl[v].src, tbl[v].len, tbl[v].base);
            run($sformatf("vec%0d", v), 100);
            expect_frame($sformatf("vec%0d_beat", v), tbl[v].src, tbl[v].beats,
                         tbl[v].base, tbl[v].err);
            check($sformatf("vec%0d_extra", v), outq.size(), 0);
            check($sformatf("vec%0d_busy", v), busy_cnt, tbl[v].len);
            check($sformatf("vec%0d_trunc", v), trunc_cnt, tbl[v].trunc);
        end

        // After truncating in2, in3 must win over in1.
        push_frame(2, 20, 'h50);
        run("trrr_a", 100);
        push_frame(1, 4, 'h70);
        push_frame(3, 4, 'h80);
        run("trrr_b", 100);
        expect_frame("trrr_t", 2, 16, 'h50, 1);
        expect_frame("trrr_3", 3, 4, 'h80, 0);
        expect_frame("trrr_1", 1, 4, 'h70, 0);
        check("trrr_extra", outq.size(), 0);

        // Fairness from rr=0, then from rr=1 with in1 holding two frames.
        do_reset();
        en = 1'b1;
        for (int i = 0; i < N; i++) push_frame(i, 4, 'h20 + 16 * i);
        run("fair_a", 200);
        for (int i = 0; i < N; i++) expect_frame($sformatf("fair_a%0d", i), i, 4, 'h20 + 16 * i, 0);
        push_frame(0, 3, 'h90);
        run("fair_p", 50);
        expect_frame("fair_p0", 0, 3, 'h90, 0);
        for (int i = 0; i < N; i++) push_frame(i, 4, 'h20 + 16 * i);
        push_frame(1, 4, 'hE0);
        run("fair_b", 200);
        expect_frame("fair_b1", 1, 4, 'h30, 0);
        expect_frame("fair_b2", 2, 4, 'h40, 0);
        expect_frame("fair_b3", 3, 4, 'h50, 0);
        expect_frame("fair_b0", 0, 4, 'h20, 0);
        expect_frame("fair_b1b", 1, 4, 'hE0, 0);
        check("fair_extra", outq.size(), 0);

        // Backpressure and mid-frame source stalls; rr is now 2.
        rnd_rdy = 1'b1;
        rnd_bub = 1'b1;
        push_frame(0, 5, 'h30);
        push_frame(1, 9, 'h40);
        push_frame(2, 3, 'h60);
        push_frame(3, 7, 'h68);
        run("bp", 600);
        expect_frame("bp2", 2, 3, 'h60, 0);
        expect_frame("bp3", 3, 7, 'h68, 0);
        expect_frame("bp0", 0, 5, 'h30, 0);
        expect_frame("bp1", 1, 9, 'h40, 0);
        check("bp_extra", outq.size(), 0);
        rnd_rdy = 1'b0;
        rnd_bub = 1'b0;

        // en_i gating, en_i drop mid-frame, then async reset mid-frame.
        do_reset();
        busy_cnt = 0;
        for (int i = 0; i < N; i++) push_frame(i, 4, 'h20 + 16 * i);
        repeat (6) tick();
        check("en0_busy", busy_cnt, 0);
        check("en0_out", outq.size(), 0);
        check("en0_ready", int'(bus.in_tready), 0);
        en = 1'b1;
        c  = 0;
        while (outq.size() < 1 && c < 20) begin tick(); c++; end
        check("en1_start", int'(outq.size() >= 1), 1);
        en = 1'b0;
        repeat (10) tick();
        expect_frame("endrop0", 0, 4, 'h20, 0);
        check("endrop_idle", int'(busy), 0);
        check("endrop_extra", outq.size(), 0);
        en = 1'b1;
        c  = 0;
        while (outq.size() < 2 && c < 20) begin tick(); c++; end
        check("mid_start", int'(outq.size() >= 2), 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ovalid", int'(bus.out_tvalid), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_grant", int'(grant), 0);
        clear_env();
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        push_frame(3, 4, 'h88);
        push_frame(0, 4, 'h08);
        run("arst", 100);
        expect_frame("arst0", 0, 4, 'h08, 0);
        expect_frame("arst3", 3, 4, 'h88, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
